// File: rtl/mult_pipe_eu.sv
// Pipelined RV64M multiply execution unit with a valid/ready handshake on both sides.
// Each stage holds valid, tag, result and exception; empty stages collapse under stalls.
module mult_pipe_eu #(
    parameter int XLEN       = 64,
    parameter int RS_DEPTH   = 16,
    parameter int PIPE_DEPTH = 3,
    parameter int EU_CTL_LEN = 4,
    parameter int EXCEPT_LEN = 2,
    localparam int IDX_W     = $clog2(RS_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [EU_CTL_LEN-1:0] ctl_i,
    input  logic [XLEN-1:0]       rs1_i,
    input  logic [XLEN-1:0]       rs2_i,
    input  logic [IDX_W-1:0]      entry_idx_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [IDX_W-1:0]      entry_idx_o,
    output logic [XLEN-1:0]       result_o,
    output logic                  except_raised_o,
    output logic [EXCEPT_LEN-1:0] except_code_o
);

    localparam int D = PIPE_DEPTH;

    localparam logic [EU_CTL_LEN-1:0] OP_MUL    = EU_CTL_LEN'(0);
    localparam logic [EU_CTL_LEN-1:0] OP_MULH   = EU_CTL_LEN'(1);
    localparam logic [EU_CTL_LEN-1:0] OP_MULHSU = EU_CTL_LEN'(2);
    localparam logic [EU_CTL_LEN-1:0] OP_MULHU  = EU_CTL_LEN'(3);
    localparam logic [EU_CTL_LEN-1:0] OP_MULW   = EU_CTL_LEN'(4);

    logic op_mul, op_mulh, op_mulhsu, op_mulhu, op_mulw;
    logic sgn1, sgn2;
    logic [2*XLEN-1:0] a_x, b_x, prod;
    logic [XLEN-1:0]       res_c;
    logic                  exc_c;
    logic [EXCEPT_LEN-1:0] code_c;

    assign op_mul    = (ctl_i == OP_MUL);
    assign op_mulh   = (ctl_i == OP_MULH);
    assign op_mulhsu = (ctl_i == OP_MULHSU);
    assign op_mulhu  = (ctl_i == OP_MULHU);
    assign op_mulw   = (ctl_i == OP_MULW);

    assign sgn1 = op_mul | op_mulh | op_mulhsu;
    assign sgn2 = op_mul | op_mulh;

    // Sign-extending to 2*XLEN makes a plain modular multiply give every mode.
    assign a_x  = {{XLEN{sgn1 & rs1_i[XLEN-1]}}, rs1_i};
    assign b_x  = {{XLEN{sgn2 & rs2_i[XLEN-1]}}, rs2_i};
    assign prod = a_x * b_x;

    always_comb begin
        res_c  = '0;
        exc_c  = 1'b0;
        code_c = '0;
        unique case (1'b1)
            op_mul:    res_c = prod[XLEN-1:0];
            op_mulh,
            op_mulhsu,
            op_mulhu:  res_c = prod[2*XLEN-1:XLEN];
            op_mulw:   res_c = {{(XLEN-32){prod[31]}}, prod[31:0]};
            default: begin
                exc_c  = 1'b1;
                code_c = EXCEPT_LEN'(1);
            end
        endcase
    end

    logic                  v_q    [D];
    logic [IDX_W-1:0]      tag_q  [D];
    logic [XLEN-1:0]       res_q  [D];
    logic                  exc_q  [D];
    logic [EXCEPT_LEN-1:0] code_q [D];

    logic                  in_v    [D];
    logic [IDX_W-1:0]      in_tag  [D];
    logic [XLEN-1:0]       in_res  [D];
    logic                  in_exc  [D];
    logic [EXCEPT_LEN-1:0] in_code [D];
    logic                  free    [D];

    assign in_v[0]    = valid_i;
    assign in_tag[0]  = entry_idx_i;
    assign in_res[0]  = res_c;
    assign in_exc[0]  = exc_c;
    assign in_code[0] = code_c;

    assign free[D-1] = !v_q[D-1] || ready_i;

    for (genvar k = 1; k < D; k++) begin : g_link
        assign in_v[k]    = v_q[k-1];
        assign in_tag[k]  = tag_q[k-1];
        assign in_res[k]  = res_q[k-1];
        assign in_exc[k]  = exc_q[k-1];
        assign in_code[k] = code_q[k-1];
        assign free[k-1]  = !v_q[k-1] || free[k];
    end

    assign ready_o = free[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < D; k++) begin
                v_q[k]    <= 1'b0;
                tag_q[k]  <= '0;
                res_q[k]  <= '0;
                exc_q[k]  <= 1'b0;
                code_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < D; k++) begin
                if (flush_i) begin
                    v_q[k] <= 1'b0;
                end else if (free[k]) begin
                    v_q[k] <= in_v[k];
                end
                if (free[k] && in_v[k]) begin
                    tag_q[k]  <= in_tag[k];
                    res_q[k]  <= in_res[k];
                    exc_q[k]  <= in_exc[k];
                    code_q[k] <= in_code[k];
                end
            end
        end
    end

    assign valid_o         = v_q[D-1];
    assign entry_idx_o     = tag_q[D-1];
    assign result_o        = res_q[D-1];
    assign except_raised_o = exc_q[D-1];
    assign except_code_o   = code_q[D-1];

endmodule

// File: tb/tb_mult_pipe_eu.sv
// Directed-vector bench for mult_pipe_eu with a queue scoreboard.
// Stimulus pushes expected results; a monitor pops them as results transfer out.
module tb_mult_pipe_eu;

    localparam int D = 3;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_o, ready_i;
    logic [3:0]  ctl_i, entry_idx_i, entry_idx_o;
    logic [63:0] rs1_i, rs2_i, result_o;
    logic        valid_o, except_raised_o;
    logic [1:0]  except_code_o;

    typedef struct packed {
        logic [3:0]  tag;
        logic [63:0] res;
        logic        exc;
        logic [1:0]  code;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    mult_pipe_eu #(.PIPE_DEPTH(D)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .ctl_i(ctl_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .entry_idx_i(entry_idx_i),
        .valid_o(valid_o), .ready_i(ready_i), .entry_idx_o(entry_idx_o),
        .result_o(result_o), .except_raised_o(except_raised_o),
        .except_code_o(except_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Called at posedge+2; returns at posedge+2 of the cycle after acceptance.
    task automatic send(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag, input logic [63:0] r);
        int   n;
        exp_t e;
        valid_i = 1'b1; ctl_i = ctl; rs1_i = a; rs2_i = b; entry_idx_i = tag;
        n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("issue_accept", {63'd0, ready_o}, 64'd1);
        e.tag  = tag;
        e.res  = (ctl > 4'd4) ? 64'd0 : r;
        e.exc  = (ctl > 4'd4);
        e.code = (ctl > 4'd4) ? 2'b01 : 2'b00;
        if (ready_o && !flush_i) sb.push_back(e);
        @(posedge clk_i); #2;
        valid_i = 1'b0;
    endtask

    task automatic lat_check();
        for (int i = 1; i < D; i++) begin
            @(negedge clk_i);
            chk("latency_early", {63'd0, valid_o}, 64'd0);
        end
        @(negedge clk_i);
        chk("latency_on_time", {63'd0, valid_o}, 64'd1);
        @(posedge clk_i); #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk_i);
        #2;
    endtask

    // Monitor: results transferring outside flush/reset must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && !flush_i && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    chk("spurious_result", {63'd0, valid_o}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("tag", {60'd0, entry_idx_o}, {60'd0, e.tag});
                    chk("result", result_o, e.res);
                    chk("except_raised", {63'd0, except_raised_o}, {63'd0, e.exc});
                    chk("except_code", {62'd0, except_code_o}, {62'd0, e.code});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        ctl_i = '0; rs1_i = '0; rs2_i = '0; entry_idx_i = '0;
        repeat (2) @(posedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("rst_result_o", result_o, 64'd0);
        chk("rst_entry_idx_o", {60'd0, entry_idx_o}, 64'd0);
        chk("rst_except_raised", {63'd0, except_raised_o}, 64'd0);
        chk("rst_except_code", {62'd0, except_code_o}, 64'd0);
        chk("rst_ready_o", {63'd0, ready_o}, 64'd1);
        @(posedge clk_i); #2;

        // Basic MUL with latency
        send(4'd0, 64'd3, 64'd5, 4'd7, 64'd15);
        lat_check();
        drain();

        // Sign modes, MULW, illegal ops, back to back
        send(4'd1, ALL1, ALL1, 4'd1, 64'h0);
        send(4'd3, ALL1, ALL1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        send(4'd2, ALL1, 64'd2, 4'd3, ALL1);
        send(4'd4, 64'h1234_5678_7FFF_FFFF, 64'd2, 4'd4, 64'hFFFF_FFFF_FFFF_FFFE);
        send(4'd9, 64'd5, 64'd6, 4'd5, 64'd0);
        send(4'd0, ALL1, ALL1, 4'd6, 64'd1);
        send(4'd4, 64'hFFFF_FFFF_8000_0000, 64'd1, 4'd8, 64'hFFFF_FFFF_8000_0000);
        send(4'd3, 64'h8000_0000_0000_0000, 64'd4, 4'd9, 64'd2);
        send(4'd1, 64'h8000_0000_0000_0000, 64'd2, 4'd10, ALL1);
        send(4'd2, 64'd3, ALL1, 4'd11, 64'd2);
        send(4'd15, ALL1, ALL1, 4'd12, 64'd0);
        send(4'd5, 64'd1, 64'd1, 4'd13, 64'd0);
        drain();

        // Backpressure: three fill the pipe, two more wait for ready_i
        ready_i = 1'b0;
        send(4'd0, 64'd1, 64'd10, 4'd1, 64'd10);
        send(4'd0, 64'd2, 64'd10, 4'd2, 64'd20);
        send(4'd0, 64'd3, 64'd10, 4'd3, 64'd30);
        @(negedge clk_i);
        chk("bp_ready_low", {63'd0, ready_o}, 64'd0);
        chk("bp_valid_held", {63'd0, valid_o}, 64'd1);
        chk("bp_head_tag", {60'd0, entry_idx_o}, 64'd1);
        @(posedge clk_i); #2;
        fork
            begin
                send(4'd0, 64'd4, 64'd10, 4'd4, 64'd40);
                send(4'd0, 64'd5, 64'd10, 4'd5, 64'd50);
            end
            begin
                repeat (2) @(posedge clk_i);
                #2 ready_i = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_i);
                    chk("bp_drain_rate", {63'd0, valid_o}, 64'd1);
                end
                @(negedge clk_i);
                chk("bp_drain_done", {63'd0, valid_o}, 64'd0);
            end
        join
        @(posedge clk_i); #2;
        drain();

        // Bubble collapse: gaps in issue still fill every stage
        ready_i = 1'b0;
        send(4'd0, 64'd7, 64'd7, 4'd1, 64'd49);
        @(posedge clk_i); #2;
        send(4'd0, 64'd8, 64'd8, 4'd2, 64'd64);
        @(negedge clk_i);
        chk("bubble_ready_two", {63'd0, ready_o}, 64'd1);
        repeat (2) @(posedge clk_i);
        #2;
        send(4'd0, 64'd9, 64'd9, 4'd3, 64'd81);
        @(negedge clk_i);
        chk("bubble_ready_full", {63'd0, ready_o}, 64'd0);
        @(posedge clk_i); #2;
        ready_i = 1'b1;
        drain();

        // Flush with three in flight and a new op offered the same cycle
        send(4'd0, 64'd2, 64'd3, 4'd1, 64'd6);
        send(4'd0, 64'd2, 64'd4, 4'd2, 64'd8);
        send(4'd0, 64'd2, 64'd5, 4'd3, 64'd10);
        flush_i = 1'b1; valid_i = 1'b1; ctl_i = 4'd0;
        rs1_i = 64'd100; rs2_i = 64'd100; entry_idx_i = 4'd14;
        @(negedge clk_i);
        sb.delete();
        @(posedge clk_i); #2;
        flush_i = 1'b0; valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_valid_o", {63'd0, valid_o}, 64'd0);
        chk("flush_ready_o", {63'd0, ready_o}, 64'd1);
        for (int i = 0; i < D + 2; i++) begin
            @(negedge clk_i);
            chk("flush_no_stale", {63'd0, valid_o}, 64'd0);
        end
        @(posedge clk_i); #2;
        send(4'd0, 64'd6, 64'd7, 4'd11, 64'd42);
        lat_check();
        drain();

        // Reset mid-stream
        send(4'd0, 64'd11, 64'd11, 4'd4, 64'd121);
        send(4'd3, ALL1, ALL1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFE);
        rst_i = 1'b1;
        @(negedge clk_i);
        sb.delete();
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("mid_rst_result_o", result_o, 64'd0);
        chk("mid_rst_entry_idx_o", {60'd0, entry_idx_o}, 64'd0);
        chk("mid_rst_except", {63'd0, except_raised_o}, 64'd0);
        chk("mid_rst_ready_o", {63'd0, ready_o}, 64'd1);
        for (int i = 0; i < D + 1; i++) begin
            @(negedge clk_i);
            chk("mid_rst_empty", {63'd0, valid_o}, 64'd0);
        end
        @(posedge clk_i); #2;
        send(4'd4, 64'hDEAD_BEEF_0000_0003, 64'd5, 4'd15, 64'd15);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
